// File: rtl/demux_pkg.sv
// Shared types and constants for the four-way stream demultiplexer.
package demux_pkg;

   localparam int NCH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   typedef logic [1:0] ch_idx_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel. A load always wins
// over a drain, so a beat arriving in the same cycle the consumer takes the
// old one simply replaces it and the valid flag stays up.
module demux_slot #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld,
   input  logic [DW-1:0] ld_dat,
   input  logic          ld_lst,
   input  logic          rdy,
   output logic          vld,
   output logic [DW-1:0] dat,
   output logic          lst
);

   logic          vld_q, vld_d;
   logic [DW-1:0] dat_q, dat_d;
   logic          lst_q, lst_d;

   // Next slot contents: load replaces, drain only drops valid (data held).
   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      lst_d = lst_q;
      if (ld) begin
         vld_d = 1'b1;
         dat_d = ld_dat;
         lst_d = ld_lst;
      end else if (rdy) begin
         vld_d = 1'b0;
      end
   end

   // Slot registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         dat_q <= '0;
         lst_q <= 1'b0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
         lst_q <= lst_d;
      end
   end

   assign vld = vld_q;
   assign dat = dat_q;
   assign lst = lst_q;

endmodule

// File: rtl/demux4.sv
// Four-way valid/ready stream demultiplexer. The destination is taken from
// in_sel on a packet's first beat and held until its last beat.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | between packets; next accepted beat is a first beat, dest=in_sel
//  BUSY  | mid-packet; dest=cur_sel, in_sel ignored until the last beat
module demux4
   import demux_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] in_dat,
   input  logic          in_lst,
   input  logic [1:0]    in_sel,
   input  logic          in_vld,
   output logic          in_rdy,
   output logic [DW-1:0] out_dat0,
   output logic [DW-1:0] out_dat1,
   output logic [DW-1:0] out_dat2,
   output logic [DW-1:0] out_dat3,
   output logic [3:0]    out_lst,
   output logic [3:0]    out_vld,
   input  logic [3:0]    out_rdy,
   output logic          busy
);

   state_e  state_q, state_d;
   ch_idx_t cur_sel_q, cur_sel_d;
   ch_idx_t dest;
   logic    acc;
   logic [3:0]    ld;
   logic [DW-1:0] dat_arr [NCH];

   // Destination select and accept handshake; in_rdy looks straight through
   // to the chosen consumer's ready so a full slot can refill while draining.
   always_comb begin
      dest   = (state_q == BUSY) ? cur_sel_q : ch_idx_t'(in_sel);
      in_rdy = ~out_vld[dest] | out_rdy[dest];
      acc    = in_vld & in_rdy;
   end

   // Packet tracking: enter BUSY on a non-last first beat, leave on the last.
   always_comb begin
      state_d   = state_q;
      cur_sel_d = cur_sel_q;
      if (acc) begin
         if (state_q == IDLE) begin
            if (!in_lst) begin
               state_d   = BUSY;
               cur_sel_d = ch_idx_t'(in_sel);
            end
         end else if (in_lst) begin
            state_d = IDLE;
         end
      end
   end

   // FSM and held channel registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cur_sel_q <= '0;
      end else begin
         state_q   <= state_d;
         cur_sel_q <= cur_sel_d;
      end
   end

   assign busy = (state_q == BUSY);

   for (genvar i = 0; i < NCH; i++) begin : g_slot
      assign ld[i] = acc & (dest == ch_idx_t'(i));

      demux_slot #(.DW(DW)) u_slot (
         .clk    (clk),
         .rst_n  (rst_n),
         .ld     (ld[i]),
         .ld_dat (in_dat),
         .ld_lst (in_lst),
         .rdy    (out_rdy[i]),
         .vld    (out_vld[i]),
         .dat    (dat_arr[i]),
         .lst    (out_lst[i])
      );
   end

   assign out_dat0 = dat_arr[0];
   assign out_dat1 = dat_arr[1];
   assign out_dat2 = dat_arr[2];
   assign out_dat3 = dat_arr[3];

endmodule

// File: tb/tb_demux4.sv
// Bench for demux4: hand-written vector table for the directed scenarios,
// a mid-packet reset sequence, then randomized traffic against a model.
module tb_demux4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_dat;
   logic       in_lst;
   logic [1:0] in_sel;
   logic       in_vld;
   logic       in_rdy;
   logic [7:0] out_dat0, out_dat1, out_dat2, out_dat3;
   logic [3:0] out_lst;
   logic [3:0] out_vld;
   logic [3:0] out_rdy;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Reference: each channel is a one-entry holding register; a packet owns
   // one channel from its first beat until its last.
   bit       m_vld [4];
   bit [7:0] m_dat [4];
   bit       m_lst [4];
   bit       m_inpkt;
   int       m_ch;

   always #5 clk = ~clk;

   demux4 #(.DW(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_dat   (in_dat),
      .in_lst   (in_lst),
      .in_sel   (in_sel),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .out_dat0 (out_dat0),
      .out_dat1 (out_dat1),
      .out_dat2 (out_dat2),
      .out_dat3 (out_dat3),
      .out_lst  (out_lst),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .busy     (busy)
   );

   function automatic logic [7:0] dut_dat(input int ch);
      case (ch)
         0:       return out_dat0;
         1:       return out_dat1;
         2:       return out_dat2;
         default: return out_dat3;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_inpkt = 1'b0;
      m_ch    = 0;
      for (int i = 0; i < 4; i++) begin
         m_vld[i] = 1'b0;
         m_dat[i] = 8'h00;
         m_lst[i] = 1'b0;
      end
   endtask

   // Drive one cycle of inputs, check against the model before the edge,
   // then advance the model by what the edge should have done.
   task automatic step(input logic [7:0] d, input logic [1:0] s, input logic l,
                       input logic v, input logic [3:0] r, output logic rdy_seen);
      int  dst;
      bit  exp_rdy;
      bit  take;
      @(negedge clk);
      in_dat  = d;
      in_sel  = s;
      in_lst  = l;
      in_vld  = v;
      out_rdy = r;
      #1;
      dst     = m_inpkt ? m_ch : int'(s);
      exp_rdy = !m_vld[dst] || r[dst];
      rdy_seen = in_rdy;
      chk("in_rdy", int'(in_rdy), int'(exp_rdy));
      chk("busy", int'(busy), int'(m_inpkt));
      for (int i = 0; i < 4; i++) begin
         chk("out_vld", int'(out_vld[i]), int'(m_vld[i]));
         if (m_vld[i]) begin
            chk("out_dat", int'(dut_dat(i)), int'(m_dat[i]));
            chk("out_lst", int'(out_lst[i]), int'(m_lst[i]));
         end
      end
      take = v && exp_rdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
         if (r[i]) m_vld[i] = 1'b0;
      if (take) begin
         m_vld[dst] = 1'b1;
         m_dat[dst] = d;
         m_lst[dst] = l;
         if (!m_inpkt && !l) begin
            m_inpkt = 1'b1;
            m_ch    = int'(s);
         end else if (m_inpkt && l) begin
            m_inpkt = 1'b0;
         end
      end
   endtask

   typedef struct {
      logic [7:0] dat;
      logic [1:0] sel;
      logic       lst;
      logic       vld;
      logic [3:0] rdy;
      logic       exp_rdy;
      logic [3:0] exp_vld;
      logic       exp_busy;
      int         chk_ch;
      logic [7:0] exp_dat;
   } vec_t;

   vec_t vecs [16];

   initial begin
      logic rs;
      int   busy_cnt;

      vecs[0]  = '{8'hA5, 2'd2, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0100, 1'b0, 2, 8'hA5};
      vecs[1]  = '{8'h11, 2'd1, 1'b0, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b1, 1, 8'h11};
      vecs[2]  = '{8'h22, 2'd3, 1'b0, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b1, 1, 8'h22};
      vecs[3]  = '{8'h33, 2'd3, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b0, 1, 8'h33};
      vecs[4]  = '{8'h00, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 1, 8'h33};
      vecs[5]  = '{8'h44, 2'd0, 1'b1, 1'b1, 4'hE, 1'b1, 4'b0001, 1'b0, 0, 8'h44};
      vecs[6]  = '{8'h55, 2'd0, 1'b1, 1'b1, 4'hE, 1'b0, 4'b0001, 1'b0, 0, 8'h44};
      vecs[7]  = '{8'h66, 2'd3, 1'b1, 1'b1, 4'hE, 1'b1, 4'b1001, 1'b0, 3, 8'h66};
      vecs[8]  = '{8'h55, 2'd0, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0001, 1'b0, 0, 8'h55};
      vecs[9]  = '{8'hD0, 2'd0, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0001, 1'b0, 0, 8'hD0};
      vecs[10] = '{8'hD1, 2'd1, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b0, 1, 8'hD1};
      vecs[11] = '{8'hD2, 2'd2, 1'b1, 1'b1, 4'hF, 1'b1, 4'b0100, 1'b0, 2, 8'hD2};
      vecs[12] = '{8'hD3, 2'd3, 1'b1, 1'b1, 4'hF, 1'b1, 4'b1000, 1'b0, 3, 8'hD3};
      vecs[13] = '{8'h00, 2'd0, 1'b0, 1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 3, 8'hD3};
      vecs[14] = '{8'h77, 2'd2, 1'b0, 1'b1, 4'h0, 1'b1, 4'b0100, 1'b1, 2, 8'h77};
      vecs[15] = '{8'h78, 2'd0, 1'b1, 1'b1, 4'h0, 1'b0, 4'b0100, 1'b1, 2, 8'h77};

      rst_n   = 1'b0;
      in_dat  = '0;
      in_sel  = '0;
      in_lst  = 1'b0;
      in_vld  = 1'b0;
      out_rdy = 4'hF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_vld", int'(out_vld), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_lst", int'(out_lst), 0);
      chk("rst_out_dat2", int'(out_dat2), 0);
      @(negedge clk);
      rst_n = 1'b1;

      busy_cnt = 0;
      for (int k = 0; k < 16; k++) begin
         step(vecs[k].dat, vecs[k].sel, vecs[k].lst, vecs[k].vld, vecs[k].rdy, rs);
         chk($sformatf("vec%0d_in_rdy", k), int'(rs), int'(vecs[k].exp_rdy));
         chk($sformatf("vec%0d_out_vld", k), int'(out_vld), int'(vecs[k].exp_vld));
         chk($sformatf("vec%0d_busy", k), int'(busy), int'(vecs[k].exp_busy));
         chk($sformatf("vec%0d_dat", k), int'(dut_dat(vecs[k].chk_ch)),
             int'(vecs[k].exp_dat));
         if (busy) busy_cnt++;
         if (k == 0) chk("single_lst2", int'(out_lst[2]), 1);
         if (k == 13) chk("pkt_busy_cycles", busy_cnt, 2);
      end

      // Vectors 14/15 left a packet open on channel 2 with slot 2 full and
      // a blocked beat; reset mid-packet must abandon it.
      @(negedge clk);
      in_vld = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("midrst_out_vld", int'(out_vld), 0);
      chk("midrst_busy", int'(busy), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(8'h81, 2'd1, 1'b0, 1'b1, 4'hF, rs);
      chk("post_rst_route_vld", int'(out_vld), 4'b0010);
      chk("post_rst_route_dat", int'(out_dat1), 8'h81);
      chk("post_rst_busy", int'(busy), 1);
      step(8'h82, 2'd2, 1'b1, 1'b1, 4'hF, rs);
      chk("post_rst_last_vld", int'(out_vld), 4'b0010);
      chk("post_rst_last_dat", int'(out_dat1), 8'h82);

      // Randomized traffic including idle gaps, back-pressure and reselects.
      for (int n = 0; n < 2000; n++) begin
         step(8'($urandom), 2'($urandom), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 3) != 0), 4'($urandom), rs);
      end
      step(8'h00, 2'd0, 1'b0, 1'b0, 4'hF, rs);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
